// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of pipeline hazard signals between the core datapath
// and hazard_ctrl.
//   slave  : hazard controller side (register indices/enables in, controls out)
//   master : datapath side (register indices/enables out, controls in)
// CNT_W must match the CNT_W of the hazard_ctrl instance it connects to.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       rs1D, rs2D;
   logic [4:0]       rs1E, rs2E;
   logic [4:0]       rdE, rdM, rdW;
   logic             loadE;
   logic             RegWriteM, RegWriteW;
   logic             PCSrcE;
   logic             memReqM, memAckM;
   logic             stallF, stallD, stallE, stallM;
   logic             flushD, flushE, flushW;
   logic [1:0]       fwdAE, fwdBE;
   logic             memErr;
   logic [CNT_W-1:0] stallCnt, flushCnt;

   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
      input  loadE, RegWriteM, RegWriteW, PCSrcE, memReqM, memAckM,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
      output fwdAE, fwdBE, memErr, stallCnt, flushCnt
   );

   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
      output loadE, RegWriteM, RegWriteW, PCSrcE, memReqM, memAckM,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
      input  fwdAE, fwdBE, memErr, stallCnt, flushCnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the five-stage pipeline.
// Handles load-use bubbles, taken-branch squashes and multi-cycle data-memory
// waits (with timeout), and keeps saturating stall/flush counters.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   io_hz : hazard_ctrl_if.slave -- register indices/enables in; stall, flush,
//           forward selects, sticky memErr and counters out
// Stall/flush/forward outputs are combinational from inputs and current state;
// state, timer, memErr and counters are registered.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave io_hz
);
   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {ST_RUN = 1'b0, ST_MEMWAIT = 1'b1} state_t;

   state_t           r_state;
   logic [TW-1:0]    r_timer;
   logic             r_mem_err;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic       w_lw_stall;
   logic       w_mem_hold;
   logic       w_br_flush;
   logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
   logic       w_flush_d, w_flush_e, w_flush_w;
   logic [1:0] w_fwd_a, w_fwd_b;

   // Forward select for one operand: Memory stage wins over Writeback.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_m,
                                          input logic [4:0] rd_m,
                                          input logic       wr_w,
                                          input logic [4:0] rd_w);
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      fwd_sel = 2'b10;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) fwd_sel = 2'b01;
      else                                             fwd_sel = 2'b00;
   endfunction

   // Hazard detection and control priority: memory hold > branch > load-use.
   always_comb begin
      w_stall_f  = 1'b0;
      w_stall_d  = 1'b0;
      w_stall_e  = 1'b0;
      w_stall_m  = 1'b0;
      w_flush_d  = 1'b0;
      w_flush_e  = 1'b0;
      w_flush_w  = 1'b0;
      w_br_flush = 1'b0;
      w_fwd_a    = 2'b00;
      w_fwd_b    = 2'b00;

      w_lw_stall = io_hz.loadE && (io_hz.rdE != 5'd0) &&
                   ((io_hz.rdE == io_hz.rs1D) || (io_hz.rdE == io_hz.rs2D));

      // In MEMWAIT the hold drops on the timeout cycle even without an ack.
      w_mem_hold = ((r_state == ST_RUN) && io_hz.memReqM && !io_hz.memAckM) ||
                   ((r_state == ST_MEMWAIT) && !io_hz.memAckM &&
                    (r_timer < TW'(MEM_TIMEOUT)));

      if (!rst) begin
         w_fwd_a = fwd_sel(io_hz.rs1E, io_hz.RegWriteM, io_hz.rdM,
                           io_hz.RegWriteW, io_hz.rdW);
         w_fwd_b = fwd_sel(io_hz.rs2E, io_hz.RegWriteM, io_hz.rdM,
                           io_hz.RegWriteW, io_hz.rdW);
         if (w_mem_hold) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
         end else if (io_hz.PCSrcE) begin
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
            w_br_flush = 1'b1;
         end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
         end
      end
   end

   // Memory-wait FSM, sticky timeout flag and saturating counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_timer     <= '0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (io_hz.memReqM && !io_hz.memAckM) begin
                  r_state <= ST_MEMWAIT;
                  r_timer <= TW'(1);
               end
            end
            ST_MEMWAIT: begin
               if (io_hz.memAckM) begin
                  r_state <= ST_RUN;
                  r_timer <= '0;
               end else if (r_timer == TW'(MEM_TIMEOUT)) begin
                  r_mem_err <= 1'b1;
                  r_state   <= ST_RUN;
                  r_timer   <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_timer <= '0;
            end
         endcase

         if (w_stall_f && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_br_flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign io_hz.stallF   = w_stall_f;
   assign io_hz.stallD   = w_stall_d;
   assign io_hz.stallE   = w_stall_e;
   assign io_hz.stallM   = w_stall_m;
   assign io_hz.flushD   = w_flush_d;
   assign io_hz.flushE   = w_flush_e;
   assign io_hz.flushW   = w_flush_w;
   assign io_hz.fwdAE    = w_fwd_a;
   assign io_hz.fwdBE    = w_fwd_b;
   assign io_hz.memErr   = r_mem_err;
   assign io_hz.stallCnt = r_stall_cnt;
   assign io_hz.flushCnt = r_flush_cnt;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core (Fetch/Decode/Execute/Memory/Writeback). It produces stall, flush and forwarding controls for the pipeline registers, including the Decode→Execute register. It sequences three situations:
- load-use bubbles;
- taken-branch squashes;
- multi-cycle data-memory waits, guarded by a timeout.

It also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 64, maximum cycles spent in MEMWAIT before an error is declared (≥2)
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rs1D, rs2D  input  5  source registers of instruction in Decode
- rs1E, rs2E  input  5  source registers of instruction in Execute
- rdE, rdM, rdW  input  5  destination registers in Execute/Memory/Writeback
- loadE  input  1  instruction in Execute is a load
- RegWriteM, RegWriteW  input  1  register-write enables in Memory/Writeback
- PCSrcE  input  1  taken branch/jump resolved in Execute
- memReqM  input  1  data-memory access active in Memory
- memAckM  input  1  data memory completes access this cycle
- stallF, stallD, stallE, stallM  output  1  hold the PC and the D/E/M pipeline registers
- flushD, flushE, flushW  output  1  load a bubble into the Decode, Execute and Writeback registers
- fwdAE, fwdBE  output  2  operand A/B forward select: 00 register file, 01 resultW, 10 ALU result in Memory
- memErr  output  1  sticky memory-timeout flag
- stallCnt, flushCnt  output  CNT_W  performance counters

## Operation
- **Forwarding** (combinational, evaluated for A using rs1E; B is identical using rs2E):
  - fwdAE=10 if RegWriteM && rdM!=0 && rdM==rs1E;
  - else fwdAE=01 if RegWriteW && rdW!=0 && rdW==rs1E;
  - else fwdAE=00.
  - Memory beats Writeback when both match.
- **lwStall** = loadE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- **State machine:** RUN, MEMWAIT. A timer of width $clog2(MEM_TIMEOUT+1) counts cycles in MEMWAIT.
- **memHold** = (RUN && memReqM && !memAckM) || (MEMWAIT && !memAckM && timer<MEM_TIMEOUT).
- **Priority: memHold > PCSrcE > lwStall.**
  - memHold: stallF=stallD=stallE=stallM=1 and flushW=1; flushD=flushE=0. Branch and load-use actions are suppressed and are re-evaluated once the hold releases.
  - else PCSrcE: flushD=flushE=1, no stalls.
  - else lwStall: stallF=stallD=1, flushE=1.
  - else all stall/flush outputs are 0.
- **Transitions:**
  - RUN→MEMWAIT when memReqM && !memAckM; timer←1.
  - MEMWAIT→RUN on memAckM. The release cycle has no memory stall.
  - MEMWAIT with timer==MEM_TIMEOUT and !memAckM: memErr←1, →RUN, and hold is released that cycle.
  - Otherwise in MEMWAIT, timer increments.
- memErr stays set until reset.
- **Counters:**
  - stallCnt increments each cycle stallF=1.
  - flushCnt increments each cycle PCSrcE causes flushE.
  - Both saturate at all-ones.
- While rst=1, every stall/flush output is 0 and fwdAE/fwdBE are 00.

## Timing
- Forwarding, stall and flush outputs are combinational: zero-cycle latency from inputs and current state.
- State, timer, memErr and counters update on the rising clk edge. The counters reflect the previous cycle's event one cycle later.
- Reset values: state RUN, timer 0, memErr 0, stallCnt 0, flushCnt 0.
- Reset asserted mid-MEMWAIT immediately forces RUN and clears timer, memErr and the counters, with no clock required.
- memReqM && memAckM in the same RUN cycle: no stall and no state change.
- A load-use stall lasts exactly one cycle: the next cycle the load is in Memory, loadE=0 for the bubble, and forwarding from Memory covers the dependency.
- rd=0 never triggers forwarding or lwStall.
- A counter at max stays at max; it does not wrap.

## Test plan
- **Forwarding.** rs1E=5, rdM=5, RegWriteM=1, rdW=5, RegWriteW=1 → fwdAE=10. Then RegWriteM=0 → 01. Then rdM=rdW=0 with rs1E=0 → 00.
- **Load-use.** loadE=1, rdE=7, rs2D=7 → one cycle of stallF=stallD=flushE=1, and stallCnt +1 next cycle. Repeat with rdE=0 → no stall.
- **Branch with concurrent load-use.** PCSrcE=1 together with lwStall conditions → flushD=flushE=1, stallF=0; flushCnt +1.
- **Memory wait.** memReqM=1 with memAckM low for 3 cycles then high → stall/flushW asserted for 3 cycles, released on the ack cycle, state returns to RUN, stallCnt +3.
- **Timeout.** MEM_TIMEOUT=4, memReqM held, ack never arrives → memErr=1 after the cycle where timer=4; hold releases; memErr stays 1 until rst.
- **Reset and saturation.** Pulse rst asynchronously mid-MEMWAIT → outputs 0 and counters 0 without a clock edge. Separately, force stallCnt to all-ones and continue stalling → it holds all-ones.
